// File: rtl/stream_demux_1to2_pkg.sv
// Shared constants for the 1-to-2 stream demux: destination select codes
// and the per-output slot state.
package stream_demux_1to2_pkg;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/stream_demux_1to2_slot.sv
// One-entry registered output slot with load/drain handshaking and a
// wrapping count of completed output transfers.
module demux_slot
  import stream_demux_1to2_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic             free,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);

  slot_state_e state;
  logic        drain;

  assign out_valid = (state == SLOT_FULL);
  assign drain     = out_valid && out_ready;
  assign free      = !out_valid || out_ready;

  // Load wins over drain so a simultaneous drain+load keeps the slot full.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= SLOT_EMPTY;
      out_data <= '0;
      count    <= '0;
    end else begin
      if (load) begin
        state    <= SLOT_FULL;
        out_data <= load_data;
      end else if (drain) begin
        state <= SLOT_EMPTY;
      end
      if (drain) begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/stream_demux_1to2.sv
// Steers one valid/ready stream to output A or B per transfer; each output
// has its own register slot so a stalled consumer never blocks the other.
module stream_demux_1to2
  import stream_demux_1to2_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] outA_data,
  output logic             outA_valid,
  input  logic             outA_ready,
  output logic [WIDTH-1:0] outB_data,
  output logic             outB_valid,
  input  logic             outB_ready,
  output logic [CNT_W-1:0] countA,
  output logic [CNT_W-1:0] countB
);

  logic slot_a_free;
  logic slot_b_free;
  logic accept;
  logic load_a;
  logic load_b;

  // in_ready looks only at the selected slot, never at in_valid.
  assign in_ready = (in_sel == SEL_B) ? slot_b_free : slot_a_free;
  assign accept   = in_valid && in_ready;
  assign load_a   = accept && (in_sel == SEL_A);
  assign load_b   = accept && (in_sel == SEL_B);

  demux_slot #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_slot_a (
    .Clk       (Clk),
    .Reset     (Reset),
    .load      (load_a),
    .load_data (in_data),
    .free      (slot_a_free),
    .out_data  (outA_data),
    .out_valid (outA_valid),
    .out_ready (outA_ready),
    .count     (countA)
  );

  demux_slot #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_slot_b (
    .Clk       (Clk),
    .Reset     (Reset),
    .load      (load_b),
    .load_data (in_data),
    .free      (slot_b_free),
    .out_data  (outB_data),
    .out_valid (outB_valid),
    .out_ready (outB_ready),
    .count     (countB)
  );

endmodule

// File: tb/tb_stream_demux_1to2.sv
// Self-checking bench for stream_demux_1to2: directed scenarios plus a
// random soak against per-output one-entry queues.
module tb_stream_demux_1to2;

  localparam int WIDTH = 8;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] outA_data;
  logic             outA_valid;
  logic             outA_ready;
  logic [WIDTH-1:0] outB_data;
  logic             outB_valid;
  logic             outB_ready;
  logic [CNT_W-1:0] countA;
  logic [CNT_W-1:0] countB;

  int checks = 0;
  int errors = 0;

  stream_demux_1to2 #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .Clk        (clk),
    .Reset      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .outA_data  (outA_data),
    .outA_valid (outA_valid),
    .outA_ready (outA_ready),
    .outB_data  (outB_data),
    .outB_valid (outB_valid),
    .outB_ready (outB_ready),
    .countA     (countA),
    .countB     (countB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_data = '0; in_sel = 1'b0; in_valid = 1'b0;
    outA_ready = 1'b0; outB_ready = 1'b0;
    #2;
    checks++;
    if (outA_valid !== 1'b0 || outB_valid !== 1'b0 || outA_data !== 8'h00 ||
        outB_data !== 8'h00 || countA !== 8'h00 || countB !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_init: got vA=%b vB=%b dA=%h dB=%h cA=%0d cB=%0d, expected all zero",
               outA_valid, outB_valid, outA_data, outB_data, countA, countB);
    end
    #1 rst_n = 1'b1;
    in_data = 8'hE7; in_sel = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (outA_valid !== 1'b1 || outA_data !== 8'hE7) begin
      errors++;
      $display("[TB] FAIL reset_preload: got vA=%b dA=%h, expected 1 e7", outA_valid, outA_data);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (outA_valid !== 1'b0 || outB_valid !== 1'b0 || countA !== 8'h00 ||
        countB !== 8'h00 || outA_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_async: got vA=%b vB=%b dA=%h cA=%0d cB=%0d, expected 0 0 00 0 0",
               outA_valid, outB_valid, outA_data, countA, countB);
    end
    rst_n = 1'b1;
    for (int s = 0; s < 2; s++) begin
      in_sel = s[0];
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL reset_ready_sel%0d: got %b expected 1", s, in_ready);
      end
    end
  endtask

  task automatic test_routing();
    outA_ready = 1'b1; outB_ready = 1'b1;
    tick();
    in_data = 8'h5A; in_sel = 1'b0; in_valid = 1'b1;
    tick();
    checks++;
    if (outA_valid !== 1'b1 || outA_data !== 8'h5A || outB_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL route_a: got vA=%b dA=%h vB=%b, expected 1 5a 0", outA_valid, outA_data, outB_valid);
    end
    in_data = 8'hC3; in_sel = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (outB_valid !== 1'b1 || outB_data !== 8'hC3 || outA_valid !== 1'b0 || countA !== 8'd1) begin
      errors++;
      $display("[TB] FAIL route_b: got vB=%b dB=%h vA=%b cA=%0d, expected 1 c3 0 1",
               outB_valid, outB_data, outA_valid, countA);
    end
    tick();
  endtask

  task automatic test_stall();
    outA_ready = 1'b1; outB_ready = 1'b0;
    in_data = 8'h77; in_sel = 1'b1; in_valid = 1'b1;
    tick();
    in_data = 8'h99;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (in_ready !== 1'b0 || outB_valid !== 1'b1 || outB_data !== 8'h77) begin
        errors++;
        $display("[TB] FAIL stall_hold_%0d: got rdy=%b vB=%b dB=%h, expected 0 1 77",
                 i, in_ready, outB_valid, outB_data);
      end
      tick();
    end
    in_sel = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      in_data = WIDTH'(k);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stall_a_ready_%0d: got %b expected 1", k, in_ready);
      end
      tick();
      checks++;
      if (outA_valid !== 1'b1 || outA_data !== WIDTH'(k) || outB_data !== 8'h77) begin
        errors++;
        $display("[TB] FAIL stall_a_word_%0d: got vA=%b dA=%h dB=%h, expected 1 %h 77",
                 k, outA_valid, outA_data, outB_data, k);
      end
    end
    in_valid = 1'b0; outB_ready = 1'b1;
    tick();
    checks++;
    if (outA_valid !== 1'b0 || outB_valid !== 1'b0 || outA_data !== 8'h04) begin
      errors++;
      $display("[TB] FAIL stall_drain: got vA=%b vB=%b dA=%h, expected 0 0 04", outA_valid, outB_valid, outA_data);
    end
  endtask

  task automatic test_drain_load();
    pulse_reset();
    outA_ready = 1'b0; outB_ready = 1'b0;
    in_data = 8'h11; in_sel = 1'b0; in_valid = 1'b1;
    tick();
    outA_ready = 1'b1; in_data = 8'h22;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL dl_ready: got %b expected 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (outA_valid !== 1'b1 || outA_data !== 8'h22 || countA !== 8'd1) begin
      errors++;
      $display("[TB] FAIL drain_load: got vA=%b dA=%h cA=%0d, expected 1 22 1", outA_valid, outA_data, countA);
    end
    tick();
  endtask

  task automatic test_wrap();
    pulse_reset();
    outA_ready = 1'b1; outB_ready = 1'b1;
    in_sel = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = WIDTH'($urandom);
      tick();
    end
    in_sel = 1'b0;
    for (int i = 0; i < 256; i++) begin
      in_data = WIDTH'(i);
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (countA !== 8'd255 || countB !== 8'd3) begin
      errors++;
      $display("[TB] FAIL wrap_pre: got cA=%0d cB=%0d, expected 255 3", countA, countB);
    end
    tick();
    checks++;
    if (countA !== 8'd0 || countB !== 8'd3) begin
      errors++;
      $display("[TB] FAIL wrap: got cA=%0d cB=%0d, expected 0 3", countA, countB);
    end
  endtask

  task automatic test_soak();
    logic [WIDTH-1:0] q_a[$];
    logic [WIDTH-1:0] q_b[$];
    int  hs_a = 0;
    int  hs_b = 0;
    int  sent = 0;
    logic exp_ready;
    bit  bad;
    pulse_reset();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_sel     = 1'($urandom);
      in_data    = WIDTH'($urandom);
      outA_ready = ($urandom_range(0, 3) != 0);
      outB_ready = ($urandom_range(0, 2) != 0);
      #1;
      exp_ready = in_sel ? (q_b.size() == 0 || outB_ready) : (q_a.size() == 0 || outA_ready);
      bad = (in_ready !== exp_ready) ||
            (outA_valid !== (q_a.size() != 0)) || (outB_valid !== (q_b.size() != 0)) ||
            (q_a.size() != 0 && outA_data !== q_a[0]) || (q_b.size() != 0 && outB_data !== q_b[0]) ||
            (countA !== CNT_W'(hs_a % 256)) || (countB !== CNT_W'(hs_b % 256));
      checks++;
      if (bad) begin
        errors++;
        $display("[TB] FAIL soak_cyc%0d: got rdy=%b vA=%b dA=%h vB=%b dB=%h cA=%0d cB=%0d, expected rdy=%b qA=%0d qB=%0d cA=%0d cB=%0d",
                 cyc, in_ready, outA_valid, outA_data, outB_valid, outB_data, countA, countB,
                 exp_ready, q_a.size(), q_b.size(), hs_a % 256, hs_b % 256);
      end
      if (q_a.size() != 0 && outA_ready) begin
        void'(q_a.pop_front());
        hs_a++;
      end
      if (q_b.size() != 0 && outB_ready) begin
        void'(q_b.pop_front());
        hs_b++;
      end
      if (in_valid && exp_ready) begin
        sent++;
        if (in_sel) q_b.push_back(in_data);
        else        q_a.push_back(in_data);
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    checks++;
    if (countA !== CNT_W'(hs_a % 256) || countB !== CNT_W'(hs_b % 256) ||
        sent != hs_a + hs_b + q_a.size() + q_b.size()) begin
      errors++;
      $display("[TB] FAIL soak_final: got cA=%0d cB=%0d, expected %0d %0d (sent=%0d)",
               countA, countB, hs_a % 256, hs_b % 256, sent);
    end
  endtask

  initial begin
    test_reset();
    test_routing();
    test_stall();
    test_drain_load();
    test_wrap();
    test_soak();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
